morse_tx_symbol_core: RTL and testbench

- Transmit-side front end of the Morse transceiver.
- Combines three parts: a bit-period timer that generates a one-cycle sample pulse, an ASCII-to-Morse lookup ROM, and a character decoder.
- The decoder fetches characters over a next handshake and expands each into 3-bit symbols.
- A downstream shift-out stage turns the symbols into the keyed line; it consumes symbols with req and steps them using sample.

---
 rtl/morse_tx_symbol_core.sv | 195 +++++++++++++++++++
 tb/tb_morse_tx_symbol_core.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/morse_tx_symbol_core.sv
// Morse transmit front end: bit-period timer, ASCII-to-Morse code ROM and a
// character decoder that fetches characters over next and expands them into
// 3-bit symbols for the downstream shift-out stage.
module morse_tx_symbol_core (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] bit_time,
    input  logic        start,
    input  logic [7:0]  char_in,
    input  logic        req,
    output logic        sample,
    output logic [2:0]  sym,
    output logic        next
);

    localparam logic [2:0] SYM_IDLE = 3'd0;
    localparam logic [2:0] SYM_DOT  = 3'd1;
    localparam logic [2:0] SYM_DASH = 3'd2;
    localparam logic [2:0] SYM_CGAP = 3'd3;
    localparam logic [2:0] SYM_WGAP = 3'd4;
    localparam logic [2:0] SYM_END  = 3'd5;

    typedef enum logic [1:0] {
        ST_INIT,
        ST_REQ,
        ST_LOAD,
        ST_EMIT
    } state_t;

    // ------------------------------------------------------------------
    // Bit-period timer
    // ------------------------------------------------------------------
    logic [31:0] cnt;
    logic [31:0] b_eff;
    logic [31:0] start_load;
    logic        wrap;

    assign b_eff = (bit_time == 32'd0) ? 32'd1 : bit_time;
    // >= keeps the counter bounded if bit_time shrinks below the current count
    assign wrap  = (cnt >= b_eff - 32'd1);

    // The start cycle itself stands for count B-1-floor(B/2), so the register
    // takes the count that follows it; this lands the next pulse floor(B/2)
    // clocks after start (one clock when B=1, where that count is already B-1).
    assign start_load = (b_eff == 32'd1) ? 32'd0 : (b_eff - (b_eff >> 1));

    // Gated by rst_n so a 1-clock period cannot pulse while held in reset.
    assign sample = rst_n & wrap & ~start;

    // Free-running period counter; start realigns and wins over wrap
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= 32'd0;
        end else if (start) begin
            cnt <= start_load;
        end else if (wrap) begin
            cnt <= 32'd0;
        end else begin
            cnt <= cnt + 32'd1;
        end
    end

    // ------------------------------------------------------------------
    // ASCII to Morse ROM: {len[2:0], pat[4:0]}, first element at pat[len-1],
    // 1 = dash. len 7 marks the specials (pat 0 word space, pat 1 end).
    // ------------------------------------------------------------------
    function automatic logic [7:0] morse_code(input logic [7:0] c);
        logic [7:0] u;
        u = ((c >= 8'h61) && (c <= 8'h7A)) ? (c - 8'h20) : c;
        case (u)
            8'h41: morse_code = 8'h41; // A .-
            8'h42: morse_code = 8'h88; // B -...
            8'h43: morse_code = 8'h8A; // C -.-.
            8'h44: morse_code = 8'h64; // D -..
            8'h45: morse_code = 8'h20; // E .
            8'h46: morse_code = 8'h82; // F ..-.
            8'h47: morse_code = 8'h66; // G --.
            8'h48: morse_code = 8'h80; // H ....
            8'h49: morse_code = 8'h40; // I ..
            8'h4A: morse_code = 8'h87; // J .---
            8'h4B: morse_code = 8'h65; // K -.-
            8'h4C: morse_code = 8'h84; // L .-..
            8'h4D: morse_code = 8'h43; // M --
            8'h4E: morse_code = 8'h42; // N -.
            8'h4F: morse_code = 8'h67; // O ---
            8'h50: morse_code = 8'h86; // P .--.
            8'h51: morse_code = 8'h8D; // Q --.-
            8'h52: morse_code = 8'h62; // R .-.
            8'h53: morse_code = 8'h60; // S ...
            8'h54: morse_code = 8'h21; // T -
            8'h55: morse_code = 8'h61; // U ..-
            8'h56: morse_code = 8'h81; // V ...-
            8'h57: morse_code = 8'h63; // W .--
            8'h58: morse_code = 8'h89; // X -..-
            8'h59: morse_code = 8'h8B; // Y -.--
            8'h5A: morse_code = 8'h8C; // Z --..
            8'h30: morse_code = 8'hBF; // 0 -----
            8'h31: morse_code = 8'hAF; // 1 .----
            8'h32: morse_code = 8'hA7; // 2 ..---
            8'h33: morse_code = 8'hA3; // 3 ...--
            8'h34: morse_code = 8'hA1; // 4 ....-
            8'h35: morse_code = 8'hA0; // 5 .....
            8'h36: morse_code = 8'hB0; // 6 -....
            8'h37: morse_code = 8'hB8; // 7 --...
            8'h38: morse_code = 8'hBC; // 8 ---..
            8'h39: morse_code = 8'hBE; // 9 ----.
            8'h20: morse_code = 8'hE0; // word space
            8'h03: morse_code = 8'hE1; // ETX -> end
            default: morse_code = 8'h00;
        endcase
    endfunction

    logic [7:0] rom_code;
    logic [2:0] rom_len;
    logic [4:0] rom_pat;
    logic [2:0] eff_len;
    logic [2:0] ld_idx;

    assign rom_code = morse_code(char_in);
    assign rom_len  = rom_code[7:5];
    assign rom_pat  = rom_code[4:0];
    // A stray len 6 is clamped to the 5 pattern bits that exist
    assign eff_len  = (rom_len > 3'd5) ? 3'd5 : rom_len;
    assign ld_idx   = eff_len - 3'd1;

    // ------------------------------------------------------------------
    // Character decoder
    // ------------------------------------------------------------------
    state_t     state;
    logic [4:0] pat;
    logic [2:0] idx;
    logic [2:0] idx_m1;

    assign idx_m1 = idx - 3'd1;

    // Fetch/expand FSM with registered sym and next
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_INIT;
            sym   <= SYM_IDLE;
            next  <= 1'b0;
            pat   <= 5'd0;
            idx   <= 3'd0;
        end else begin
            next <= 1'b0;
            case (state)
                ST_INIT: begin
                    state <= ST_REQ;
                    next  <= 1'b1;
                end
                ST_REQ: begin
                    state <= ST_LOAD;
                end
                ST_LOAD: begin
                    pat <= rom_pat;
                    if (rom_len == 3'd0) begin
                        // unsupported byte: skip it and fetch again
                        state <= ST_REQ;
                        next  <= 1'b1;
                    end else begin
                        state <= ST_EMIT;
                        if (rom_len == 3'd7) begin
                            sym <= rom_pat[0] ? SYM_END : SYM_WGAP;
                        end else begin
                            idx <= ld_idx;
                            sym <= rom_pat[ld_idx] ? SYM_DASH : SYM_DOT;
                        end
                    end
                end
                ST_EMIT: begin
                    if (req) begin
                        if ((sym == SYM_DOT) || (sym == SYM_DASH)) begin
                            if (idx == 3'd0) begin
                                sym <= SYM_CGAP;
                            end else begin
                                idx <= idx_m1;
                                sym <= pat[idx_m1] ? SYM_DASH : SYM_DOT;
                            end
                        end else begin
                            // gap or end was the last symbol of this character
                            sym   <= SYM_IDLE;
                            state <= ST_REQ;
                            next  <= 1'b1;
                        end
                    end
                end
                default: begin
                    state <= ST_INIT;
                    sym   <= SYM_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_morse_tx_symbol_core.sv
// Bench for morse_tx_symbol_core: directed timer checks plus a randomized
// character stream scored against a string-table Morse model.
module tb_morse_tx_symbol_core;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] bit_time = 32'd20;
    logic        start = 1'b0;
    logic [7:0]  char_in = 8'h00;
    logic        req = 1'b0;
    logic        sample;
    logic [2:0]  sym;
    logic        next;

    morse_tx_symbol_core dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bit_time (bit_time),
        .start    (start),
        .char_in  (char_in),
        .req      (req),
        .sample   (sample),
        .sym      (sym),
        .next     (next)
    );

    always #5 clk = ~clk;

    int         errors = 0;
    int         checks = 0;
    logic [2:0] exp_q[$];
    logic [7:0] dir_q[$];
    bit         rand_en = 1'b0;
    bit         req_en = 1'b0;
    logic [7:0] cur_char = 8'h00;
    int         rand_issued = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, expv);
        end
    endtask

    // Reference: international Morse as dot/dash strings
    function automatic string morse_of(input logic [7:0] c);
        logic [7:0] u;
        u = c;
        if (u >= 8'h61 && u <= 8'h7A) u = u - 8'h20;
        case (u)
            "A": return ".-";    "B": return "-...";  "C": return "-.-.";
            "D": return "-..";   "E": return ".";     "F": return "..-.";
            "G": return "--.";   "H": return "....";  "I": return "..";
            "J": return ".---";  "K": return "-.-";   "L": return ".-..";
            "M": return "--";    "N": return "-.";    "O": return "---";
            "P": return ".--.";  "Q": return "--.-";  "R": return ".-.";
            "S": return "...";   "T": return "-";     "U": return "..-";
            "V": return "...-";  "W": return ".--";   "X": return "-..-";
            "Y": return "-.--";  "Z": return "--..";
            "0": return "-----"; "1": return ".----"; "2": return "..---";
            "3": return "...--"; "4": return "....-"; "5": return ".....";
            "6": return "-...."; "7": return "--..."; "8": return "---..";
            "9": return "----.";
            default: return "";
        endcase
    endfunction

    // Expected symbol stream for one character, IDLE marks its completion
    task automatic push_model(input logic [7:0] c);
        string m;
        if (c == 8'h20) begin
            exp_q.push_back(3'd4);
            exp_q.push_back(3'd0);
        end else if (c == 8'h03) begin
            exp_q.push_back(3'd5);
            exp_q.push_back(3'd0);
        end else begin
            m = morse_of(c);
            if (m.len() > 0) begin
                for (int i = 0; i < m.len(); i++)
                    exp_q.push_back((m[i] == 8'h2D) ? 3'd2 : 3'd1);
                exp_q.push_back(3'd3);
                exp_q.push_back(3'd0);
            end
        end
    endtask

    function automatic logic [7:0] pick_random();
        case ($urandom_range(0, 5))
            0: return 8'(8'h41 + $urandom_range(0, 25));
            1: return 8'(8'h61 + $urandom_range(0, 25));
            2: return 8'(8'h30 + $urandom_range(0, 9));
            3: return 8'h20;
            4: return 8'h03;
            default: return 8'($urandom_range(0, 255));
        endcase
    endfunction

    // Character source: answers each next pulse and records expectations
    initial begin : char_driver
        logic [7:0] c;
        forever begin
            @(negedge clk);
            if (rst_n && next) begin
                if (dir_q.size() > 0) c = dir_q.pop_front();
                else if (rand_en) begin
                    c = pick_random();
                    rand_issued++;
                end else c = 8'h00;
                char_in  = c;
                cur_char = c;
                push_model(c);
            end
        end
    end

    // Shift-out stand-in: random req pulses, occasionally while idle
    initial begin : req_driver
        forever begin
            @(posedge clk);
            #1;
            if (!rst_n || !req_en) req = 1'b0;
            else if (sym != 3'd0) req = ($urandom_range(0, 2) != 0);
            else req = ($urandom_range(0, 7) == 0);
        end
    end

    // Monitor: pops an expectation whenever a new symbol is presented
    initial begin : monitor
        logic [2:0] prev_sym;
        logic       prev_req;
        logic       prev_next;
        prev_sym = 3'd0; prev_req = 1'b0; prev_next = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_sym = 3'd0; prev_req = 1'b0; prev_next = 1'b0;
            end else begin
                if ((prev_req && prev_sym != 3'd0) || (prev_sym == 3'd0 && sym != 3'd0)) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL sym_unexpected: got %0d expected none", sym);
                    end else begin
                        check("sym", 32'(sym), 32'(exp_q.pop_front()));
                    end
                end else if (sym != prev_sym) begin
                    check("sym_hold", 32'(sym), 32'(prev_sym));
                end
                if (next) begin
                    check("next_while_idle", 32'(sym), 32'd0);
                    check("next_one_cycle", 32'(prev_next), 32'd0);
                end
                prev_sym  = sym;
                prev_req  = req;
                prev_next = next;
            end
        end
    end

    // Called just after a rising edge; releases reset and times the restart
    task automatic after_release();
        int n;
        n = 0;
        rst_n = 1'b1;
        do begin
            @(negedge clk);
            n++;
            if (n == 1) check("init_no_next", 32'(next), 32'd0);
            if (n == 2) check("first_next", 32'(next), 32'd1);
        end while (!sample && n < 200);
        check("first_pulse", n, 20);
    endtask

    task automatic expect_pulse(input string name, input int expv);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!sample && n < 200);
        check(name, n, expv);
    endtask

    task automatic wait_drain(input string name);
        int k;
        k = 0;
        while ((dir_q.size() != 0 || exp_q.size() != 0) && k < 20000) begin
            @(posedge clk);
            k++;
        end
        check(name, 32'(exp_q.size() + dir_q.size()), 32'd0);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "watchdog");
    end

    initial begin : main
        int k;
        dir_q = '{8'h41, 8'h00, 8'h00, 8'h42, 8'h41, 8'h42, 8'h20,
                  8'h43, 8'h44, 8'h03, 8'h45};

        // reset state, including a 1-clock period held in reset
        bit_time = 32'd1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_sample", 32'(sample), 32'd0);
        check("rst_sym", 32'(sym), 32'd0);
        check("rst_next", 32'(next), 32'd0);
        bit_time = 32'd20;

        @(posedge clk);
        #1;
        req_en = 1'b1;
        after_release();
        expect_pulse("period20_a", 20);
        expect_pulse("period20_b", 20);

        // start mid-period
        repeat (5) @(posedge clk);
        #1 start = 1'b1;
        @(negedge clk);
        check("start_mid_no_pulse", 32'(sample), 32'd0);
        @(posedge clk);
        #1 start = 1'b0;
        expect_pulse("start_mid_half", 10);
        expect_pulse("start_mid_period", 20);

        // start in the very cycle that would have wrapped
        repeat (20) @(posedge clk);
        #1 start = 1'b1;
        @(negedge clk);
        check("start_over_wrap", 32'(sample), 32'd0);
        @(posedge clk);
        #1 start = 1'b0;
        expect_pulse("wrap_start_half", 10);
        expect_pulse("wrap_start_period", 20);

        // bit_time 0 behaves as 1: pulse every clock
        @(posedge clk);
        #1 bit_time = 32'd0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("bt0_every_clock", 32'(sample), 32'd1);
        end
        @(posedge clk);
        #1 start = 1'b1;
        @(negedge clk);
        check("bt0_start_suppress", 32'(sample), 32'd0);
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        check("bt0_start_next", 32'(sample), 32'd1);

        // odd period realigned by start
        @(posedge clk);
        #1 begin bit_time = 32'd7; start = 1'b1; end
        @(posedge clk);
        #1 start = 1'b0;
        expect_pulse("bt7_half", 3);
        expect_pulse("bt7_period", 7);

        @(posedge clk);
        #1 begin bit_time = 32'd20; start = 1'b1; end
        @(posedge clk);
        #1 start = 1'b0;
        expect_pulse("bt20_half", 10);
        expect_pulse("bt20_period", 20);

        // directed character sequence fully consumed
        wait_drain("directed_drain");

        // random character stream
        rand_en = 1'b1;
        k = 0;
        while (rand_issued < 80 && k < 20000) begin
            @(posedge clk);
            k++;
        end
        check("random_issued", 32'(rand_issued >= 80), 32'd1);
        rand_en = 1'b0;
        wait_drain("random_drain");

        // reset in the middle of emitting 'C'
        dir_q.push_back(8'h43);
        k = 0;
        do begin
            @(posedge clk);
            #2;
            k++;
        end while (!(cur_char == 8'h43 && sym != 3'd0) && k < 2000);
        check("c_emitting", 32'(cur_char == 8'h43 && sym != 3'd0), 32'd1);
        rst_n = 1'b0;
        #1;
        check("midrst_sym", 32'(sym), 32'd0);
        check("midrst_next", 32'(next), 32'd0);
        check("midrst_sample", 32'(sample), 32'd0);
        exp_q.delete();
        dir_q.push_back(8'h45);
        dir_q.push_back(8'h54);
        repeat (2) @(posedge clk);
        #1;
        after_release();
        wait_drain("post_reset_drain");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
